wb_regfile: RTL and testbench

//  Write-back stage plus architectural register file of the 5-stage MIPS pipeline. Consumes
//  the MA/WB pipeline register outputs and selects the ALU or memory result, with sub-word load

---
 rtl/wb_regfile.sv | 144 ++++++++++++++
 tb/tb_wb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: MIPS write-back stage and 32x32 architectural register file.
// Selects the ALU or the formatted load result, commits it to the register
// file, and serves two bypassed read ports. The current write-back is also
// exported to the forwarding unit. A retired-instruction counter and a sticky
// misaligned-load flag are kept for debug.
module wb_regfile #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          BIG_ENDIAN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       WB_W,
  input  logic [31:0]      ALUOutW,
  input  logic [31:0]      MEMOutW,
  input  logic [31:0]      inst_w,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [31:0]      rs_data,
  output logic [31:0]      rt_data,
  output logic             wb_we,
  output logic [4:0]       wb_addr,
  output logic [31:0]      wb_data,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             misalign_err
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic        reg_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic [5:0]  opcode;
  logic [1:0]  byte_sel;
  logic        half_sel;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        misaligned;

  logic [31:0]      regfile_reg [32];
  logic [CNT_W-1:0] retired_cnt_reg;
  logic             misalign_reg;

  // Instruction fields that the write-back stage does not look at
  logic unused_bits;
  assign unused_bits = ^{inst_w[25:21], inst_w[10:0], ALUOutW[31:2]};

  assign {reg_write, mem_to_reg, reg_dst} = WB_W;
  assign opcode = inst_w[31:26];

  // Byte lane numbering flips with endianness; byte 0 is the lowest address
  assign byte_sel  = BIG_ENDIAN ? ~ALUOutW[1:0] : ALUOutW[1:0];
  assign half_sel  = BIG_ENDIAN ? ~ALUOutW[1]   : ALUOutW[1];
  assign load_byte = MEMOutW[{byte_sel, 3'b000} +: 8];
  assign load_half = MEMOutW[{half_sel, 4'b0000} +: 16];

  // Load formatting and alignment check; only loads can be misaligned
  always_comb begin
    load_data  = MEMOutW;
    misaligned = 1'b0;
    case (opcode)
      OP_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      OP_LBU: load_data = {24'b0, load_byte};
      OP_LH: begin
        load_data  = {{16{load_half[15]}}, load_half};
        misaligned = ALUOutW[0];
      end
      OP_LHU: begin
        load_data  = {16'b0, load_half};
        misaligned = ALUOutW[0];
      end
      OP_LW: begin
        load_data  = MEMOutW;
        misaligned = |ALUOutW[1:0];
      end
      default: begin
        load_data  = MEMOutW;
        misaligned = |ALUOutW[1:0];
      end
    endcase
    if (!mem_to_reg) begin
      misaligned = 1'b0;
    end
  end

  assign wb_addr = reg_dst ? inst_w[15:11] : inst_w[20:16];
  assign wb_data = mem_to_reg ? load_data : ALUOutW;
  assign wb_we   = reg_write & (wb_addr != 5'd0) & ~misaligned;

  // Register file commit; $0 is never written because wb_we excludes it
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regfile_reg[i] <= '0;
      end
    end else if (wb_we) begin
      regfile_reg[wb_addr] <= wb_data;
    end
  end

  // Two identical read ports with write-first bypass from the current write-back
  logic [4:0]  rd_addr [2];
  logic [31:0] rd_data [2];
  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd_port
      assign rd_data[gi] = (rd_addr[gi] == 5'd0)                ? 32'd0   :
                           (wb_we && (rd_addr[gi] == wb_addr)) ? wb_data :
                                                                  regfile_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs_data = rd_data[0];
  assign rt_data = rd_data[1];

  // Retired counter counts every non-bubble instruction and wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_reg <= '0;
    end else if (inst_w != 32'd0) begin
      retired_cnt_reg <= retired_cnt_reg + 1'b1;
    end
  end

  // Misaligned-load flag stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_reg <= 1'b0;
    end else if (misaligned) begin
      misalign_reg <= 1'b1;
    end
  end

  assign retired_cnt  = retired_cnt_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vectors for wb_regfile (CNT_W=4 to exercise wrap).
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [2:0]  WB_W;
  logic [31:0] ALUOutW;
  logic [31:0] MEMOutW;
  logic [31:0] inst_w;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  retired_cnt;
  logic        misalign_err;

  int n_vec = 0;
  int n_err = 0;

  wb_regfile #(.CNT_W(4), .BIG_ENDIAN(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .WB_W         (WB_W),
    .ALUOutW      (ALUOutW),
    .MEMOutW      (MEMOutW),
    .inst_w       (inst_w),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .retired_cnt  (retired_cnt),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Instruction word: opcode, rt, rd, with a nonzero funct so it is never a bubble
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd);
    return {op, 5'd0, rt, rd, 5'd0, 6'h21};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WB_W    = 3'b000;
    inst_w  = 32'd0;
    ALUOutW = 32'd0;
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [1:0]  off;
    logic [4:0]  rt;
    logic [31:0] exp;
    string       tag;
  } load_vec_t;

  load_vec_t loads [5];
  logic [3:0] wrap_exp [5];

  initial begin
    loads[0] = '{6'h20, 2'd1, 5'd10, 32'h0000007F, "lb_off1"};
    loads[1] = '{6'h20, 2'd3, 5'd11, 32'hFFFFFF80, "lb_off3"};
    loads[2] = '{6'h24, 2'd2, 5'd12, 32'h000000FF, "lbu_off2"};
    loads[3] = '{6'h21, 2'd2, 5'd13, 32'hFFFF80FF, "lh_off2"};
    loads[4] = '{6'h25, 2'd0, 5'd14, 32'h00007F01, "lhu_off0"};
    wrap_exp[0] = 4'd14;
    wrap_exp[1] = 4'd15;
    wrap_exp[2] = 4'd0;
    wrap_exp[3] = 4'd1;
    wrap_exp[4] = 4'd2;

    rst = 1'b1;
    MEMOutW = 32'd0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state: every register reads zero, counters cleared
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i);
      rt_addr = 5'(31 - i);
      #1;
      check($sformatf("rst_rs_r%0d", i), rs_data, 32'd0);
    end
    check("rst_rt_r31", rt_data, 32'd0);
    check("rst_cnt", 32'(retired_cnt), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);

    // R-type write to $5 with same-cycle bypass on both ports
    WB_W = 3'b101; inst_w = mk(6'h00, 5'd0, 5'd5); ALUOutW = 32'hDEADBEEF;
    rs_addr = 5'd5; rt_addr = 5'd5;
    #1;
    check("byp_we", 32'(wb_we), 32'd1);
    check("byp_addr", 32'(wb_addr), 32'd5);
    check("byp_rs", rs_data, 32'hDEADBEEF);
    check("byp_rt", rt_data, 32'hDEADBEEF);
    tick();
    idle();
    #1;
    check("array_rs", rs_data, 32'hDEADBEEF);
    check("cnt_after_1", 32'(retired_cnt), 32'd1);

    // Write to $0 is discarded
    WB_W = 3'b101; inst_w = mk(6'h00, 5'd0, 5'd0); ALUOutW = 32'd1; rs_addr = 5'd0;
    #1;
    check("r0_we", 32'(wb_we), 32'd0);
    check("r0_bypass", rs_data, 32'd0);
    tick();
    idle();
    #1;
    check("r0_after", rs_data, 32'd0);

    // Sub-word loads from a fixed memory word
    MEMOutW = 32'h80FF7F01;
    foreach (loads[k]) begin
      WB_W = 3'b110;
      inst_w = mk(loads[k].op, loads[k].rt, 5'd0);
      ALUOutW = 32'h1000 | 32'(loads[k].off);
      #1;
      check({loads[k].tag, "_data"}, wb_data, loads[k].exp);
      check({loads[k].tag, "_addr"}, 32'(wb_addr), 32'(loads[k].rt));
      tick();
    end
    idle();
    foreach (loads[k]) begin
      rt_addr = loads[k].rt;
      #1;
      check({loads[k].tag, "_reg"}, rt_data, loads[k].exp);
    end

    // Misaligned lw leaves its target untouched and sets the sticky flag
    WB_W = 3'b101; inst_w = mk(6'h00, 5'd0, 5'd20); ALUOutW = 32'h12345678;
    tick();
    WB_W = 3'b110; inst_w = mk(6'h23, 5'd20, 5'd0); ALUOutW = 32'h00001002;
    MEMOutW = 32'hCAFEF00D; rs_addr = 5'd20;
    #1;
    check("mis_we", 32'(wb_we), 32'd0);
    check("mis_nobypass", rs_data, 32'h12345678);
    tick();
    idle();
    #1;
    check("mis_reg", rs_data, 32'h12345678);
    check("mis_flag", 32'(misalign_err), 32'd1);
    tick();
    tick();
    check("mis_sticky", 32'(misalign_err), 32'd1);
    check("cnt_after_9", 32'(retired_cnt), 32'd9);

    // Non-writing instructions bring the counter to 13 without touching $5
    rs_addr = 5'd5;
    for (int i = 0; i < 4; i++) begin
      WB_W = 3'b001; inst_w = mk(6'h00, 5'd0, 5'd5); ALUOutW = 32'hFFFFFFFF;
      #1;
      check($sformatf("nowr_we_%0d", i), 32'(wb_we), 32'd0);
      tick();
    end
    idle();
    #1;
    check("nowr_r5", rs_data, 32'hDEADBEEF);
    check("cnt_13", 32'(retired_cnt), 32'd13);

    // Bubbles do not count
    for (int i = 0; i < 3; i++) tick();
    check("cnt_bubbles", 32'(retired_cnt), 32'd13);

    // Five instructions step the counter through the wrap
    for (int i = 0; i < 5; i++) begin
      WB_W = 3'b000; inst_w = mk(6'h00, 5'd0, 5'd9);
      tick();
      check($sformatf("cnt_wrap_%0d", i), 32'(retired_cnt), 32'(wrap_exp[i]));
    end

    // Reset mid-stream drops the pending write
    rst = 1'b1;
    WB_W = 3'b101; inst_w = mk(6'h00, 5'd0, 5'd7); ALUOutW = 32'hAAAAAAAA;
    tick();
    rst = 1'b0;
    idle();
    rs_addr = 5'd7; rt_addr = 5'd5;
    #1;
    check("rst2_r7", rs_data, 32'd0);
    check("rst2_r5", rt_data, 32'd0);
    check("rst2_cnt", 32'(retired_cnt), 32'd0);
    check("rst2_misalign", 32'(misalign_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
